// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester arbiter family: the fixed-priority
// arbiter, this grant-hold stage and the planned round-robin variant.
//   NUM_REQ       : number of requesters
//   GNT_NONE      : arbiter code for "no request"; any code >= GNT_NONE means none
//   grant_state_t : grant-hold FSM states
//   end_cause_t   : reason a burst ended
package arb_pkg;

  localparam int         NUM_REQ  = 4;
  localparam logic [2:0] GNT_NONE = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } grant_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LAST    = 2'd1,
    CAUSE_DROP    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } end_cause_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic [1:0] idx);
    owner_onehot      = '0;
    owner_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/arbiter_grant_hold_if.sv
// Bus between the arbiter/requesters and the grant-hold stage.
//   gnt_id, req, beat, last : arbiter result, raw requests, owner beat qualifiers
//   gnt, owner, busy        : registered grant state
//   beat_cnt, done, end_cause : burst progress and end-of-burst report
// Modports: master = requester/arbiter side, slave = grant-hold stage.
interface arbiter_grant_hold_if #(
  parameter int MAX_BEATS = 8
);
  import arb_pkg::*;

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [2:0]         gnt_id;
  logic [NUM_REQ-1:0] req;
  logic               beat;
  logic               last;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         owner;
  logic               busy;
  logic [CNT_W-1:0]   beat_cnt;
  logic               done;
  logic [1:0]         end_cause;

  modport master (
    output gnt_id, req, beat, last,
    input  gnt, owner, busy, beat_cnt, done, end_cause
  );

  modport slave (
    input  gnt_id, req, beat, last,
    output gnt, owner, busy, beat_cnt, done, end_cause
  );

endinterface

// File: rtl/arbiter_grant_hold_watchdog.sv
// grant_watchdog: idle timer for the grant-hold stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the timer from zero (takes priority over inc)
//   inc        : count one beat-less cycle; saturates at TIMEOUT
//   expired    : the timer reaches TIMEOUT with this cycle's update;
//                constant 0 when TIMEOUT = 0 (timeout disabled)
module grant_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_disabled
    logic unused_ok;
    assign unused_ok = clr | inc;
    assign expired   = 1'b0;
  end else begin : g_timer
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      timer_d = timer_q;
      if (clr) begin
        timer_d = '0;
      end else if (inc && (timer_q != TW'(TIMEOUT))) begin
        timer_d = timer_q + TW'(1);
      end
    end

    // Looking at the next value lets the owner release on the TIMEOUT-th
    // beat-less cycle rather than one cycle later.
    assign expired = (timer_d == TW'(TIMEOUT));

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_d;
      end
    end
  end

endmodule

// File: rtl/arbiter_grant_hold.sv
// arbiter_grant_hold: latches the fixed-priority arbiter's winner and holds a
// registered one-hot grant for one bounded burst, followed by a single GAP
// cycle so the arbiter re-evaluates against fresh requests.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of arbiter_grant_hold_if
//                in : gnt_id (0-3 winner, >=4 none), req, beat, last
//                out: gnt, owner, busy, beat_cnt, done, end_cause (all registered)
// A burst ends on a last beat or the MAX_BEATS-th beat, on the owner
// dropping its request, or after TIMEOUT beat-less cycles (0 disables).
module arbiter_grant_hold
  import arb_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arbiter_grant_hold_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  grant_state_t       state_q,     state_d;
  logic [1:0]         owner_q,     owner_d;
  logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_q,       gnt_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  end_cause_t         end_cause_q, end_cause_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               wd_clr;
  logic               wd_inc;
  logic               wd_expired;

  // The count never passes MAX_BEATS: reaching it ends the burst.
  assign cnt_inc = beat_cnt_q + CNT_W'(1);

  grant_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    end_cause_d = CAUSE_NONE;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.gnt_id < GNT_NONE) begin
          owner_d    = bus.gnt_id[1:0];
          beat_cnt_d = '0;
          wd_clr     = 1'b1;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        wd_clr = bus.beat;
        wd_inc = !bus.beat;
        // A beat in the exit cycle is counted regardless of the exit cause.
        if (bus.beat) begin
          beat_cnt_d = cnt_inc;
        end
        if (bus.beat && (bus.last || (cnt_inc == CNT_W'(MAX_BEATS)))) begin
          end_cause_d = CAUSE_LAST;
          state_d     = GAP;
        end else if (!bus.req[owner_q]) begin
          end_cause_d = CAUSE_DROP;
          state_d     = GAP;
        end else if (wd_expired) begin
          end_cause_d = CAUSE_TIMEOUT;
          state_d     = GAP;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    busy_d = (state_d == BUSY);
    done_d = (state_d == GAP);
    gnt_d  = busy_d ? owner_onehot(owner_d) : '0;
  end

  // NOTE: the asynchronous reset drops gnt/busy immediately, mid-burst,
  // without waiting for a clock edge and without producing a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      end_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      end_cause_q <= end_cause_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.done      = done_q;
  assign bus.end_cause = end_cause_q;

endmodule
